// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator stack slice.
// Holds the arbiter state encoding, default sizes and ASCII codes.
package calc_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    PUSH_WAIT,
    POP_WAIT
  } arb_state_e;

  typedef enum logic {
    CL_A = 1'b0,
    CL_B = 1'b1
  } client_e;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SPACE = 8'h20;

endpackage

// File: rtl/stack_arb.sv
// Two-client round-robin arbiter in front of a shared stack.
// Owner push/pop strobes are forwarded; full/empty are answered locally.
module stack_arb
  import calc_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          A_REQ,
  input  logic          B_REQ,
  output logic          A_GNT,
  output logic          B_GNT,
  input  logic          A_PUSH_STB,
  input  logic [DW-1:0] A_PUSH_DAT,
  output logic          A_PUSH_ACK,
  input  logic          A_POP_STB,
  output logic [DW-1:0] A_POP_DAT,
  output logic          A_POP_ACK,
  input  logic          B_PUSH_STB,
  input  logic [DW-1:0] B_PUSH_DAT,
  output logic          B_PUSH_ACK,
  input  logic          B_POP_STB,
  output logic [DW-1:0] B_POP_DAT,
  output logic          B_POP_ACK,
  output logic          S_PUSH_STB,
  output logic [DW-1:0] S_PUSH_DAT,
  input  logic          S_PUSH_ACK,
  output logic          S_POP_STB,
  input  logic [DW-1:0] S_POP_DAT,
  input  logic          S_POP_ACK,
  output logic [CW-1:0] DEPTH_CNT,
  output logic          OVF,
  output logic          UNF
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  arb_state_e state_q, state_d;
  client_e    owner_q, owner_d;
  client_e    last_q, last_d;
  client_e    pick;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          spush_q, spush_d;
  logic [DW-1:0] sdat_q, sdat_d;
  logic          spop_q, spop_d;

  logic [1:0]         push_ack_q, push_ack_d;
  logic [1:0]         pop_ack_q, pop_ack_d;
  logic [1:0][DW-1:0] pop_dat_q, pop_dat_d;

  logic          own_b;
  logic          own_req;
  logic          own_push;
  logic          own_pop;
  logic [DW-1:0] own_dat;
  logic          ack_busy;

  assign own_b    = (owner_q == CL_B);
  assign own_req  = own_b ? B_REQ : A_REQ;
  assign own_push = own_b ? B_PUSH_STB : A_PUSH_STB;
  assign own_pop  = own_b ? B_POP_STB : A_POP_STB;
  assign own_dat  = own_b ? B_PUSH_DAT : A_PUSH_DAT;

  // The requester still holds STB during its ACK cycle.
  assign ack_busy = |push_ack_q | |pop_ack_q;

  always_comb begin
    pick = CL_A;
    if (A_REQ && B_REQ) begin
      pick = (last_q == CL_B) ? CL_A : CL_B;
    end else if (B_REQ) begin
      pick = CL_B;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    spush_d    = spush_q;
    sdat_d     = sdat_q;
    spop_d     = spop_q;
    push_ack_d = 2'b00;
    pop_ack_d  = 2'b00;
    pop_dat_d  = pop_dat_q;
    unique case (state_q)
      IDLE: begin
        if (A_REQ || B_REQ) begin
          owner_d = pick;
          last_d  = pick;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!own_req && !own_push && !own_pop) begin
          state_d = IDLE;
        end else if (!ack_busy && own_push) begin
          if (cnt_q < FULL) begin
            spush_d = 1'b1;
            sdat_d  = own_dat;
            state_d = PUSH_WAIT;
          end else begin
            push_ack_d[own_b] = 1'b1;
            ovf_d             = 1'b1;
          end
        end else if (!ack_busy && own_pop) begin
          if (cnt_q != '0) begin
            spop_d  = 1'b1;
            state_d = POP_WAIT;
          end else begin
            pop_dat_d[own_b] = '0;
            pop_ack_d[own_b] = 1'b1;
            unf_d            = 1'b1;
          end
        end
      end
      PUSH_WAIT: begin
        if (S_PUSH_ACK) begin
          spush_d           = 1'b0;
          cnt_d             = cnt_q + CW'(1);
          push_ack_d[own_b] = 1'b1;
          state_d           = OWN;
        end
      end
      POP_WAIT: begin
        if (S_POP_ACK) begin
          spop_d           = 1'b0;
          cnt_d            = cnt_q - CW'(1);
          pop_dat_d[own_b] = S_POP_DAT;
          pop_ack_d[own_b] = 1'b1;
          state_d          = OWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= CL_A;
      last_q     <= CL_B;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      spush_q    <= 1'b0;
      sdat_q     <= '0;
      spop_q     <= 1'b0;
      push_ack_q <= 2'b00;
      pop_ack_q  <= 2'b00;
      pop_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      spush_q    <= spush_d;
      sdat_q     <= sdat_d;
      spop_q     <= spop_d;
      push_ack_q <= push_ack_d;
      pop_ack_q  <= pop_ack_d;
      pop_dat_q  <= pop_dat_d;
    end
  end

  assign A_GNT      = (state_q != IDLE) && (owner_q == CL_A);
  assign B_GNT      = (state_q != IDLE) && (owner_q == CL_B);
  assign A_PUSH_ACK = push_ack_q[0];
  assign B_PUSH_ACK = push_ack_q[1];
  assign A_POP_ACK  = pop_ack_q[0];
  assign B_POP_ACK  = pop_ack_q[1];
  assign A_POP_DAT  = pop_dat_q[0];
  assign B_POP_DAT  = pop_dat_q[1];
  assign S_PUSH_STB = spush_q;
  assign S_PUSH_DAT = sdat_q;
  assign S_POP_STB  = spop_q;
  assign DEPTH_CNT  = cnt_q;
  assign OVF        = ovf_q;
  assign UNF        = unf_q;

endmodule
